// File: rtl/instr_issue_if.sv
// Handshake and control bundle between fetch/datapath and instr_issue_ctrl.
// master = the issue controller, slave = fetch, ALU, register file, memory and PC side.
interface instr_issue_if #(
  parameter int CNT_W = 16
);
  // instr moves when instr_valid && instr_ready are both high at a rising clk edge.
  // The producer holds instr stable while valid and not ready. instr_ready is registered.
  logic [8:0]       instr;
  logic             instr_valid;
  logic             instr_ready;
  logic [2:0]       alu_op;
  logic [2:0]       rs_addr;
  logic [2:0]       rt_addr;
  logic [5:0]       imm;
  logic             shift_dir;
  logic [2:0]       shift_amt;
  logic             reg_we;
  logic [2:0]       wr_addr;
  logic             mem_req;
  logic             mem_we;
  logic             mem_ack;
  logic             br_req;
  logic             cmp_ne;
  logic             pc_load;
  logic             flush;
  logic             mem_err;
  logic [CNT_W-1:0] instr_count;
  logic             halted;

  modport master (
    input  instr, instr_valid, mem_ack, cmp_ne,
    output instr_ready, alu_op, rs_addr, rt_addr, imm, shift_dir, shift_amt,
           reg_we, wr_addr, mem_req, mem_we, br_req, pc_load, flush,
           mem_err, instr_count, halted
  );

  modport slave (
    output instr, instr_valid, mem_ack, cmp_ne,
    input  instr_ready, alu_op, rs_addr, rt_addr, imm, shift_dir, shift_amt,
           reg_we, wr_addr, mem_req, mem_we, br_req, pc_load, flush,
           mem_err, instr_count, halted
  );
endinterface

// File: rtl/instr_issue_ctrl.sv
// Decode/issue controller for the 9-bit CPU: registered control, memory wait and branch resolve.
// Define HALT_DETECT_EN to treat 9'h1FF as a halt instruction (halted output stays 0 otherwise).
module instr_issue_ctrl #(
  parameter logic [2:0] LDI_DST     = 3'd0,
  parameter int         MEM_TIMEOUT = 15,
  parameter int         CNT_W       = 16
) (
  input  logic          clk,
  input  logic          reset,
  instr_issue_if.master bus,
  output logic [1:0]    stateDbg
);
  localparam logic [2:0] OP_AND = 3'd0, OP_ADD = 3'd1, OP_XOR = 3'd2, OP_LSH = 3'd3;
  localparam logic [2:0] OP_LDI = 3'd4, OP_LDM = 3'd5, OP_STR = 3'd6, OP_BNE = 3'd7;
  localparam logic [3:0] TIMEOUT_LIM = 4'(MEM_TIMEOUT);

`ifdef HALT_DETECT_EN
  typedef enum logic [1:0] {RUN = 2'd0, MEM_WAIT = 2'd1, BR_WAIT = 2'd2, HALT = 2'd3} state_t;
`else
  typedef enum logic [1:0] {RUN = 2'd0, MEM_WAIT = 2'd1, BR_WAIT = 2'd2} state_t;
`endif

  state_t     state, stateNext;
  logic [3:0] waitCnt;
  logic       brPhase;   // 0: br_req cycle, 1: cmp_ne is valid
  logic       accept, isHalt, retire, timeout, brTaken;
  logic [2:0] opcode;

  assign opcode   = bus.instr[8:6];
  assign accept   = bus.instr_valid && bus.instr_ready;
  assign stateDbg = state;
`ifdef HALT_DETECT_EN
  assign isHalt = (bus.instr == 9'h1FF);
`else
  assign isHalt = 1'b0;
`endif

  always_comb begin
    stateNext = state;
    retire    = 1'b0;
    timeout   = 1'b0;
    brTaken   = 1'b0;
    case (state)
      RUN: if (accept) begin
        if (isHalt) begin
`ifdef HALT_DETECT_EN
          stateNext = HALT;
`endif
          retire = 1'b1;
        end else if (opcode == OP_LDM || opcode == OP_STR) begin
          stateNext = MEM_WAIT;
        end else if (opcode == OP_BNE) begin
          stateNext = BR_WAIT;
        end else begin
          retire = 1'b1;
        end
      end
      MEM_WAIT: begin
        if (bus.mem_ack) begin
          retire    = 1'b1;
          stateNext = RUN;
        end else if (waitCnt == TIMEOUT_LIM) begin
          timeout   = 1'b1;
          retire    = 1'b1;
          stateNext = RUN;
        end
      end
      BR_WAIT: if (brPhase) begin
        brTaken   = bus.cmp_ne;
        retire    = 1'b1;
        stateNext = RUN;
      end
      default: stateNext = state;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= RUN;
      waitCnt <= 4'd0;
      brPhase <= 1'b0;
    end else begin
      state   <= stateNext;
      waitCnt <= (state == MEM_WAIT) ? waitCnt + 4'd1 : 4'd0;
      brPhase <= (state == BR_WAIT) && !brPhase;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bus.instr_ready <= 1'b0;
      bus.alu_op      <= 3'd0;
      bus.rs_addr     <= 3'd0;
      bus.rt_addr     <= 3'd0;
      bus.imm         <= 6'd0;
      bus.shift_dir   <= 1'b0;
      bus.shift_amt   <= 3'd0;
      bus.reg_we      <= 1'b0;
      bus.wr_addr     <= 3'd0;
      bus.mem_req     <= 1'b0;
      bus.mem_we      <= 1'b0;
      bus.br_req      <= 1'b0;
      bus.pc_load     <= 1'b0;
      bus.flush       <= 1'b0;
      bus.mem_err     <= 1'b0;
      bus.instr_count <= '0;
    end else begin
      bus.reg_we  <= 1'b0;
      bus.mem_req <= 1'b0;
      bus.br_req  <= 1'b0;
      bus.pc_load <= brTaken;
      bus.flush   <= brTaken;
      // A taken branch holds off issue for the flush cycle so the wrong-path word is not accepted.
      bus.instr_ready <= (stateNext == RUN) && !brTaken;
      if (retire)  bus.instr_count <= bus.instr_count + CNT_W'(1);
      if (timeout) bus.mem_err <= 1'b1;
      if (state == RUN && accept) begin
        bus.alu_op <= opcode;
        case (opcode)
          OP_AND, OP_ADD, OP_XOR: begin
            bus.rs_addr <= bus.instr[5:3];
            bus.rt_addr <= bus.instr[2:0];
            bus.reg_we  <= 1'b1;
            bus.wr_addr <= bus.instr[5:3];
          end
          OP_LSH: begin
            bus.rs_addr   <= bus.instr[5:3];
            bus.shift_dir <= bus.instr[2];
            bus.shift_amt <= {1'b0, bus.instr[1:0]} + 3'd1;
            bus.reg_we    <= 1'b1;
            bus.wr_addr   <= bus.instr[5:3];
          end
          OP_LDI: begin
            bus.imm     <= bus.instr[5:0];
            bus.reg_we  <= 1'b1;
            bus.wr_addr <= LDI_DST;
          end
          OP_LDM, OP_STR: begin
            bus.rs_addr <= bus.instr[5:3];
            bus.rt_addr <= bus.instr[2:0];
            bus.mem_req <= 1'b1;
            bus.mem_we  <= (opcode == OP_STR);
          end
          default: begin
            bus.rs_addr <= bus.instr[5:3];
            bus.rt_addr <= bus.instr[2:0];
            bus.br_req  <= !isHalt;
          end
        endcase
      end
      if (state == MEM_WAIT && bus.mem_ack && !bus.mem_we) begin
        bus.reg_we  <= 1'b1;
        bus.wr_addr <= bus.rs_addr;
      end
    end
  end

`ifdef HALT_DETECT_EN
  always_ff @(posedge clk) begin
    if (reset) bus.halted <= 1'b0;
    else if (state == RUN && accept && isHalt) bus.halted <= 1'b1;
  end
`else
  assign bus.halted = 1'b0;
`endif
endmodule

// File: tb/tb_instr_issue_ctrl.sv
// Directed plus randomized bench for instr_issue_ctrl against a per-instruction event model.
module tb_instr_issue_ctrl;
  localparam int         CNT_W       = 4;
  localparam logic [2:0] LDI_DST     = 3'd5;
  localparam int         MEM_TIMEOUT = 15;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [1:0] stateDbg;
  int total = 0;
  int bad   = 0;

  instr_issue_if #(.CNT_W(CNT_W)) bus ();
  instr_issue_ctrl #(.LDI_DST(LDI_DST), .MEM_TIMEOUT(MEM_TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .bus(bus), .stateDbg(stateDbg)
  );

  always #5 clk = ~clk;

  // expected architectural view, derived from the opcode rules
  logic [2:0]       eAlu, eRs, eRt, eWr, eAmt;
  logic [5:0]       eImm;
  logic             eDir, eMemWe, eErr, eHalted;
  logic [CNT_W-1:0] eCount;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic applyReset();
    reset = 1'b1;
    bus.instr_valid = 1'b0;
    bus.mem_ack = 1'b0;
    bus.cmp_ne = 1'b0;
    for (int c = 0; c < 2; c++) begin
      tick();
      check("rst_outs", 32'({bus.alu_op, bus.rs_addr, bus.rt_addr, bus.imm, bus.shift_dir,
                             bus.shift_amt, bus.reg_we, bus.wr_addr, bus.mem_req, bus.mem_we,
                             bus.br_req, bus.pc_load, bus.flush, bus.mem_err, bus.instr_ready,
                             bus.halted}), 32'd0);
      check("rst_count", 32'(bus.instr_count), 32'd0);
    end
    reset = 1'b0;
    tick();
    check("rst_ready", 32'(bus.instr_ready), 32'd1);
    check("rst_count_after", 32'(bus.instr_count), 32'd0);
    {eAlu, eRs, eRt, eWr, eAmt, eImm, eDir, eMemWe, eErr, eHalted} = '0;
    eCount = '0;
  endtask

  // Issues one instruction when ready, then watches until the controller is ready again.
  task automatic runInstr(input logic [8:0] ins, input int ackDelay, input logic cmpNe);
    logic [2:0] op, weAddr;
    logic       halt, isMem;
    int expWe, expMem, expBr, expPc, expRdy;
    int weN, memN, brN, pcN, flN, weCyc, memCyc, brCyc, pcCyc, rdyCyc;
    op = ins[8:6];
    isMem = (op == 3'd5 || op == 3'd6);
    halt = 1'b0;
`ifdef HALT_DETECT_EN
    halt = (ins == 9'h1FF);
`endif
    expWe = -1; expMem = -1; expBr = -1; expPc = -1; expRdy = 1;
    eAlu = op;
    if (halt) begin
      eRs = ins[5:3]; eRt = ins[2:0]; eHalted = 1'b1; expRdy = -1;
    end else if (op <= 3'd2) begin
      eRs = ins[5:3]; eRt = ins[2:0]; eWr = ins[5:3]; expWe = 1;
    end else if (op == 3'd3) begin
      eRs = ins[5:3]; eWr = ins[5:3]; eDir = ins[2]; eAmt = 3'(ins[1:0]) + 3'd1; expWe = 1;
    end else if (op == 3'd4) begin
      eImm = ins[5:0]; eWr = LDI_DST; expWe = 1;
    end else if (isMem) begin
      eRs = ins[5:3]; eRt = ins[2:0]; eMemWe = (op == 3'd6); expMem = 1;
      if (ackDelay > MEM_TIMEOUT) begin
        eErr = 1'b1; expRdy = MEM_TIMEOUT + 2;
      end else begin
        expRdy = ackDelay + 2;
        if (op == 3'd5) begin expWe = ackDelay + 2; eWr = ins[5:3]; end
      end
    end else begin
      eRs = ins[5:3]; eRt = ins[2:0]; expBr = 1;
      if (cmpNe) begin expPc = 3; expRdy = 4; end else expRdy = 3;
    end
    eCount = eCount + 1'b1;

    bus.instr = ins;
    bus.instr_valid = 1'b1;
    tick();
    weN = 0; memN = 0; brN = 0; pcN = 0; flN = 0;
    weCyc = -1; memCyc = -1; brCyc = -1; pcCyc = -1; rdyCyc = -1; weAddr = 3'd0;
    for (int k = 1; k <= 40; k++) begin
      if (bus.reg_we)  begin weN++; weCyc = k; weAddr = bus.wr_addr; end
      if (bus.mem_req) begin memN++; memCyc = k; end
      if (bus.br_req)  begin brN++; brCyc = k; end
      if (bus.pc_load) begin pcN++; pcCyc = k; end
      if (bus.flush)   flN++;
      if (bus.instr_ready) begin rdyCyc = k; break; end
      bus.instr_valid = 1'($urandom);
      bus.instr = 9'($urandom);
      bus.mem_ack = (isMem && !halt) ? (k == ackDelay + 1) : 1'($urandom);
      bus.cmp_ne = (k == 2) ? cmpNe : 1'($urandom);
      tick();
    end
    bus.instr_valid = 1'b0;
    bus.mem_ack = 1'($urandom);
    bus.cmp_ne = 1'($urandom);

    check("ready_cycle", 32'(rdyCyc), 32'(expRdy));
    check("reg_we_pulses", 32'(weN), (expWe < 0) ? 32'd0 : 32'd1);
    if (expWe >= 0) begin
      check("reg_we_cycle", 32'(weCyc), 32'(expWe));
      check("wr_addr_at_we", 32'(weAddr), 32'(eWr));
    end
    check("mem_req_pulses", 32'(memN), (expMem < 0) ? 32'd0 : 32'd1);
    if (expMem >= 0) check("mem_req_cycle", 32'(memCyc), 32'(expMem));
    check("br_req_pulses", 32'(brN), (expBr < 0) ? 32'd0 : 32'd1);
    if (expBr >= 0) check("br_req_cycle", 32'(brCyc), 32'(expBr));
    check("pc_load_pulses", 32'(pcN), (expPc < 0) ? 32'd0 : 32'd1);
    check("flush_pulses", 32'(flN), (expPc < 0) ? 32'd0 : 32'd1);
    if (expPc >= 0) check("pc_load_cycle", 32'(pcCyc), 32'(expPc));
    check("alu_op", 32'(bus.alu_op), 32'(eAlu));
    check("rs_addr", 32'(bus.rs_addr), 32'(eRs));
    check("rt_addr", 32'(bus.rt_addr), 32'(eRt));
    check("imm", 32'(bus.imm), 32'(eImm));
    check("shift", 32'({bus.shift_dir, bus.shift_amt}), 32'({eDir, eAmt}));
    check("wr_addr_held", 32'(bus.wr_addr), 32'(eWr));
    check("mem_we", 32'(bus.mem_we), 32'(eMemWe));
    check("mem_err", 32'(bus.mem_err), 32'(eErr));
    check("halted", 32'(bus.halted), 32'(eHalted));
    check("instr_count", 32'(bus.instr_count), 32'(eCount));
  endtask

  initial begin
    logic [8:0] ins;
    int d;
    bus.instr = 9'd0;
    bus.instr_valid = 1'b0;
    bus.mem_ack = 1'b0;
    bus.cmp_ne = 1'b0;
    applyReset();

    runInstr(9'b001_010_011, 0, 1'b0);
    runInstr(9'b100_101010, 0, 1'b0);
    check("imm_42", 32'(bus.imm), 32'd42);
    check("count_two", 32'(bus.instr_count), 32'd2);
    runInstr(9'b101_001_010, 3, 1'b0);
    runInstr(9'b101_001_010, 0, 1'b0);
    runInstr(9'b110_011_100, 15, 1'b0);
    runInstr(9'b101_001_010, 30, 1'b0);
    runInstr(9'b111_001_010, 0, 1'b1);
    runInstr(9'b111_001_010, 0, 1'b0);
    runInstr(9'b011_100_110, 0, 1'b0);
    check("lsh_amt", 32'(bus.shift_amt), 32'd3);
    runInstr(9'b011_001_000, 0, 1'b0);

    for (int i = 0; i < 70; i++) begin
      ins = 9'($urandom);
`ifdef HALT_DETECT_EN
      if (ins == 9'h1FF) ins = 9'h1FE;
`endif
      d = ($urandom_range(0, 7) == 0) ? $urandom_range(14, 17) : $urandom_range(0, 3);
      runInstr(ins, d, 1'($urandom_range(0, 1)));
    end

    // reset in the middle of a memory wait: no write may surface afterwards
    bus.instr = 9'b101_011_001;
    bus.instr_valid = 1'b1;
    bus.mem_ack = 1'b0;
    tick();
    bus.instr_valid = 1'b0;
    tick();
    applyReset();
    bus.mem_ack = 1'b1;
    tick();
    check("stray_ack_we", 32'(bus.reg_we), 32'd0);
    check("stray_ack_count", 32'(bus.instr_count), 32'd0);
    bus.mem_ack = 1'b0;

    runInstr(9'b010_110_001, 0, 1'b0);
    runInstr(9'h1FF, 0, 1'b0);
    check("after_1ff_ready", 32'(bus.instr_ready), 32'(!eHalted));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
